nn_feature_loader: RTL and testbench

Front-end feeder for the neural-network classifier: accepts speech features as a valid/ready stream, assembles one complete frame into a double-buffered register bank, and holds it stable on the classifier's parallel input for the full pipeline depth. It then samples the 2-bit class result and reports it with a one-cycle valid pulse. It sits between the feature-extraction front end and the classifier top, which has no handshake of its own.

---
 rtl/nn_feature_loader_pkg.sv | 20 ++
 rtl/nn_feature_loader_bank.sv | 27 ++
 rtl/nn_feature_loader.sv | 152 +++++++++++++++
 tb/tb_nn_feature_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_feature_loader_pkg.sv
// nn_parameters: shared sizes, feature type and FSM encodings
// for the classifier front-end feeder (nn_feature_loader).
package nn_parameters;

   localparam int IN_SIZE_1  = 4;
   localparam int NN_LATENCY = 5;

   typedef logic [15:0] feature_t;

   typedef enum logic {
      FILL,
      PENDING
   } fill_state_t;

   typedef enum logic {
      IDLE,
      RUN
   } run_state_t;

endpackage

// File: rtl/nn_feature_loader_bank.sv
// nn_feature_bank: N x W register bank, one indexed write port,
// full parallel read (rdata[i*W +: W] = entry i), sync clear.
module nn_feature_bank #(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            we,
   input  logic [IW-1:0]   widx,
   input  logic [W-1:0]    wdata,
   output logic [N*W-1:0]  rdata
);

   logic [N-1:0][W-1:0] mem;

   always_ff @(posedge clk) begin
      if (clr)
         mem <= '0;
      else if (we)
         mem[widx] <= wdata;
   end

   assign rdata = mem;

endmodule

// File: rtl/nn_feature_loader.sv
// nn_feature_loader: stream -> ping-pong frame banks -> classifier input.
// Ports: clk/rst (sync, active-low), s_feat_* valid/ready stream in,
// nn_input_vector (active bank), nn_output_value in, class_out/
// class_valid result, frame_error pulse, busy while classifier runs.
module nn_feature_loader
   import nn_parameters::*;
#(
   parameter int IN_SIZE    = nn_parameters::IN_SIZE_1,
   parameter int FEAT_W     = 16,
   parameter int NN_LATENCY = nn_parameters::NN_LATENCY
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FEAT_W-1:0]         s_feat_data,
   input  logic                      s_feat_valid,
   input  logic                      s_feat_last,
   output logic                      s_feat_ready,
   output logic [IN_SIZE*FEAT_W-1:0] nn_input_vector,
   input  logic [1:0]                nn_output_value,
   output logic [1:0]                class_out,
   output logic                      class_valid,
   output logic                      frame_error,
   output logic                      busy
);

   localparam int IW = $clog2(IN_SIZE);
   localparam int CW = $clog2(NN_LATENCY + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(IN_SIZE - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NN_LATENCY);

   fill_state_t fstate, fnext;
   run_state_t  rstate, rnext;

   logic [IW-1:0] idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic sel, live;
   logic accept, at_last, bad, run_end, run_free;
   logic swap, we;
   logic [IN_SIZE*FEAT_W-1:0] rd0, rd1;

   assign accept  = s_feat_valid && s_feat_ready;
   assign at_last = (idx == LAST_IDX);
   // last must coincide exactly with the final slot
   assign bad     = accept && (s_feat_last != at_last);
   assign run_end = (rstate == RUN) && (cnt == LAST_CNT);
   assign run_free = (rstate == IDLE) || run_end;

   always_comb begin
      fnext = fstate;
      idx_n = idx;
      swap  = 1'b0;
      we    = 1'b0;
      unique case (fstate)
         FILL: begin
            if (accept) begin
               if (bad) begin
                  idx_n = '0;
               end else begin
                  we = 1'b1;
                  if (at_last) begin
                     idx_n = '0;
                     if (run_free)
                        swap = 1'b1;
                     else
                        fnext = PENDING;
                  end else begin
                     idx_n = idx + 1'b1;
                  end
               end
            end
         end
         PENDING: begin
            if (run_free) begin
               swap  = 1'b1;
               fnext = FILL;
            end
         end
      endcase
   end

   always_comb begin
      rnext = rstate;
      cnt_n = cnt;
      unique case (rstate)
         IDLE: begin
            if (swap) begin
               rnext = RUN;
               cnt_n = '0;
            end
         end
         RUN: begin
            if (run_end) begin
               cnt_n = '0;
               if (!swap)
                  rnext = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fstate      <= FILL;
         rstate      <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         sel         <= 1'b0;
         live        <= 1'b0;
         class_out   <= 2'b00;
         class_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         fstate      <= fnext;
         rstate      <= rnext;
         idx         <= idx_n;
         cnt         <= cnt_n;
         live        <= 1'b1;
         class_valid <= run_end;
         frame_error <= bad;
         if (swap)
            sel <= ~sel;
         if (run_end)
            class_out <= nn_output_value;
      end
   end

   // sel picks the active bank; the other one is being filled
   nn_feature_bank #(.N(IN_SIZE), .W(FEAT_W), .IW(IW)) u_bank0 (
      .clk   (clk),
      .clr   (!rst),
      .we    (we && sel),
      .widx  (idx),
      .wdata (s_feat_data),
      .rdata (rd0)
   );

   nn_feature_bank #(.N(IN_SIZE), .W(FEAT_W), .IW(IW)) u_bank1 (
      .clk   (clk),
      .clr   (!rst),
      .we    (we && !sel),
      .widx  (idx),
      .wdata (s_feat_data),
      .rdata (rd1)
   );

   assign nn_input_vector = sel ? rd1 : rd0;
   assign s_feat_ready    = live && (fstate == FILL);
   assign busy            = (rstate == RUN);

endmodule

// File: tb/tb_nn_feature_loader.sv
// Directed bench for nn_feature_loader (IN_SIZE=4, NN_LATENCY=5)
// with a 5-stage behavioural classifier returning data[0][1:0].
module tb_nn_feature_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] s_feat_data = '0;
   logic        s_feat_valid = 1'b0;
   logic        s_feat_last = 1'b0;
   logic        s_feat_ready;
   logic [63:0] nn_input_vector;
   logic [1:0]  nn_output_value;
   logic [1:0]  class_out;
   logic        class_valid;
   logic        frame_error;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cv_count = 0;
   logic [1:0] cv_q[$];
   logic [1:0] pipe [5] = '{default: 2'b00};

   always #5 clk = ~clk;

   nn_feature_loader #(
      .IN_SIZE(4), .FEAT_W(16), .NN_LATENCY(5)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_feat_data     (s_feat_data),
      .s_feat_valid    (s_feat_valid),
      .s_feat_last     (s_feat_last),
      .s_feat_ready    (s_feat_ready),
      .nn_input_vector (nn_input_vector),
      .nn_output_value (nn_output_value),
      .class_out       (class_out),
      .class_valid     (class_valid),
      .frame_error     (frame_error),
      .busy            (busy)
   );

   always @(posedge clk) begin
      pipe[0] <= nn_input_vector[1:0];
      for (int i = 1; i < 5; i++)
         pipe[i] <= pipe[i-1];
   end
   assign nn_output_value = pipe[4];

   always @(negedge clk) begin
      if (class_valid) begin
         cv_q.push_back(class_out);
         cv_count++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic l,
                       input bit gaps);
      int n;
      if (gaps && ($urandom_range(0, 1) == 1))
         step();
      s_feat_data  = d;
      s_feat_last  = l;
      s_feat_valid = 1'b1;
      n = 0;
      while (!s_feat_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         tests++;
         fails++;
         $error("FAIL send_timeout observed=%0d expected=<50", n);
      end
      step();
      s_feat_valid = 1'b0;
      s_feat_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] f, input bit gaps);
      logic [63:0] v;
      v = f;
      for (int i = 0; i < 4; i++)
         send(v[i*16 +: 16], (i == 3), gaps);
   endtask

   localparam logic [63:0] FA = 64'h0030_0020_0010_0003;
   localparam logic [63:0] FB = 64'h0031_0021_0011_0001;
   localparam logic [63:0] FC = 64'h0032_0022_0012_0002;
   localparam logic [63:0] FD = 64'h00D3_00D2_00D1_0001;
   localparam logic [63:0] FE = 64'h0008_0006_0004_0002;
   localparam logic [63:0] F1 = 64'h0D04_0C03_0B02_0A01;
   localparam logic [63:0] F2 = 64'h4D44_3C33_2B22_1E02;
   localparam logic [63:0] F3 = 64'h7D77_6C66_5B55_2F03;

   initial begin
      int base;
      int n0;

      // reset state
      repeat (3) step();
      chk("rst_ready", s_feat_ready, 0);
      chk("rst_vec", nn_input_vector, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cv", class_valid, 0);
      chk("rst_ferr", frame_error, 0);
      chk("rst_cls", class_out, 0);
      rst = 1'b1;
      step();
      chk("rel_ready", s_feat_ready, 1);

      // single frame
      send_frame(FA, 0);
      chk("a_vec", nn_input_vector, FA);
      chk("a_busy", busy, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("a_busy_run", busy, 1);
         chk("a_cv_early", class_valid, 0);
      end
      step();
      chk("a_cv", class_valid, 1);
      chk("a_cls", class_out, 2'b11);
      chk("a_busy_end", busy, 0);
      step();
      chk("a_cv_pulse", class_valid, 0);

      // back-to-back frames
      send_frame(FB, 0);
      chk("b_vec", nn_input_vector, FB);
      send_frame(FC, 0);
      chk("c_pend_ready", s_feat_ready, 0);
      step();
      chk("c_pend_ready2", s_feat_ready, 0);
      chk("c_hold_vec", nn_input_vector, FB);
      step();
      chk("b_cv", class_valid, 1);
      chk("b_cls", class_out, 2'b01);
      chk("c_vec", nn_input_vector, FC);
      chk("c_busy", busy, 1);
      chk("c_ready", s_feat_ready, 1);
      repeat (5) step();
      chk("c_cv_early", class_valid, 0);
      step();
      chk("c_cv", class_valid, 1);
      chk("c_cls", class_out, 2'b10);
      step();

      // early last
      send(16'h0002, 0, 0);
      send(16'h0005, 1, 0);
      chk("e1_ferr", frame_error, 1);
      chk("e1_busy", busy, 0);
      chk("e1_vec", nn_input_vector, FC);
      step();
      chk("e1_ferr_pulse", frame_error, 0);
      send_frame(FD, 0);
      chk("d_vec", nn_input_vector, FD);
      repeat (6) step();
      chk("d_cv", class_valid, 1);
      chk("d_cls", class_out, 2'b01);
      step();

      // missing last
      for (int i = 0; i < 4; i++)
         send(16'h00E0 + 16'(i), 0, 0);
      chk("e2_ferr", frame_error, 1);
      chk("e2_busy", busy, 0);
      chk("e2_vec", nn_input_vector, FD);
      step();

      // reset at cnt==3
      send_frame(FE, 0);
      repeat (3) step();
      chk("r_busy", busy, 1);
      n0 = cv_count;
      rst = 1'b0;
      step();
      chk("r_ready", s_feat_ready, 0);
      chk("r_vec", nn_input_vector, 0);
      chk("r_busy0", busy, 0);
      chk("r_cv", class_valid, 0);
      chk("r_ferr", frame_error, 0);
      chk("r_cls", class_out, 0);
      rst = 1'b1;
      step();
      chk("r_rel_ready", s_feat_ready, 1);
      repeat (8) step();
      chk("r_no_cv", cv_count, n0);

      // random valid gaps
      base = cv_q.size();
      send_frame(F1, 1);
      send_frame(F2, 1);
      send_frame(F3, 1);
      repeat (30) step();
      chk("g_count", cv_q.size() - base, 3);
      if (cv_q.size() >= base + 3) begin
         chk("g_cls1", cv_q[base], 2'b01);
         chk("g_cls2", cv_q[base+1], 2'b10);
         chk("g_cls3", cv_q[base+2], 2'b11);
      end
      chk("g_vec", nn_input_vector, F3);
      chk("g_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
